// File: rtl/reg_write_if.sv
// Write-request channel into the register bank: valid/ready handshake carrying
// a target select, an op code and data.
interface reg_write_if #(
    parameter int WIDTH = 16
);
    logic             wr_valid;
    logic             wr_ready;
    logic [2:0]       wr_cmd;
    logic [1:0]       wr_op;
    logic [WIDTH-1:0] wr_data;

    modport master (
        output wr_valid,
        output wr_cmd,
        output wr_op,
        output wr_data,
        input  wr_ready
    );

    modport slave (
        input  wr_valid,
        input  wr_cmd,
        input  wr_op,
        input  wr_data,
        output wr_ready
    );
endinterface

// File: rtl/reg_write.sv
// Write side of the CPU register bank r0..r7 with a one-entry request buffer
// and an r7 (PC) increment path. Define R0_ZERO_EN to hard-wire r0 to zero.
module reg_write #(
    parameter int               WIDTH    = 16,
    parameter logic [WIDTH-1:0] R7_RESET = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    reg_write_if.slave       wr,
    input  logic             hold,
    input  logic             pc_inc,
    output logic [WIDTH-1:0] r0,
    output logic [WIDTH-1:0] r1,
    output logic [WIDTH-1:0] r2,
    output logic [WIDTH-1:0] r3,
    output logic [WIDTH-1:0] r4,
    output logic [WIDTH-1:0] r5,
    output logic [WIDTH-1:0] r6,
    output logic [WIDTH-1:0] r7
);

    localparam logic [1:0] OP_LOAD  = 2'b00;
    localparam logic [1:0] OP_LOADH = 2'b01;
    localparam logic [1:0] OP_INC   = 2'b10;
    localparam logic [1:0] OP_DEC   = 2'b11;

    function automatic logic [WIDTH-1:0] inc_wrap(input logic [WIDTH-1:0] cur);
        return cur + WIDTH'(1);
    endfunction

    function automatic logic [WIDTH-1:0] dec_wrap(input logic [WIDTH-1:0] cur);
        return cur - WIDTH'(1);
    endfunction

    function automatic logic [WIDTH-1:0] apply_op(
        input logic [WIDTH-1:0] cur,
        input logic [1:0]       op,
        input logic [WIDTH-1:0] data
    );
        logic [WIDTH-1:0] res;
        res = cur;
        case (op)
            OP_LOAD:  res = data;
            OP_LOADH: res[15:8] = data[7:0];
            OP_INC:   res = inc_wrap(cur);
            OP_DEC:   res = dec_wrap(cur);
            default:  res = cur;
        endcase
        return res;
    endfunction

    logic             vld_p0;
    logic [2:0]       cmd_p0;
    logic [1:0]       op_p0;
    logic [WIDTH-1:0] data_p0;

    logic             accept;
    logic             apply;
    logic [7:0]       wen;

    // The buffer may refill in the same cycle it drains, so ready only drops
    // while a held entry is sitting in it.
    assign wr.wr_ready = !vld_p0 || !hold;
    assign accept      = wr.wr_valid && wr.wr_ready;
    assign apply       = vld_p0 && !hold;

    always_comb begin
        wen = '0;
        if (apply) begin
            wen[cmd_p0] = 1'b1;
        end
    end

    // ---- stage p0: request buffer ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p0 <= 1'b0;
        end else if (accept) begin
            vld_p0 <= 1'b1;
        end else if (apply) begin
            vld_p0 <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            cmd_p0  <= wr.wr_cmd;
            op_p0   <= wr.wr_op;
            data_p0 <= wr.wr_data;
        end
    end

    // ---- stage p1: register file update ----
    logic [WIDTH-1:0] rf [1:7];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 1; i < 7; i++) begin
                rf[i] <= '0;
            end
            rf[7] <= R7_RESET;
        end else begin
            for (int i = 1; i < 7; i++) begin
                if (wen[i]) begin
                    rf[i] <= apply_op(rf[i], op_p0, data_p0);
                end
            end
            // An applied write to r7 overrides, and drops, that cycle's PC increment.
            if (wen[7]) begin
                rf[7] <= apply_op(rf[7], op_p0, data_p0);
            end else if (pc_inc) begin
                rf[7] <= inc_wrap(rf[7]);
            end
        end
    end

`ifdef R0_ZERO_EN
    assign r0 = '0;
`else
    logic [WIDTH-1:0] r0_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r0_q <= '0;
        end else if (wen[0]) begin
            r0_q <= apply_op(r0_q, op_p0, data_p0);
        end
    end

    assign r0 = r0_q;
`endif

    assign r1 = rf[1];
    assign r2 = rf[2];
    assign r3 = rf[3];
    assign r4 = rf[4];
    assign r5 = rf[5];
    assign r6 = rf[6];
    assign r7 = rf[7];

endmodule

// File: tb/tb_reg_write.sv
// Directed bench for reg_write: reset, ops, hold back-pressure, PC increment
// interplay, r0 behaviour and async reset during a pending request.
module tb_reg_write;

    localparam int          W      = 16;
    localparam logic [15:0] R7_RST = 16'hF000;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          hold;
    logic          pc_inc;
    logic [W-1:0]  r0, r1, r2, r3, r4, r5, r6, r7;

    int total = 0;
    int bad   = 0;

    reg_write_if #(.WIDTH(W)) bus ();

    reg_write #(.WIDTH(W), .R7_RESET(R7_RST)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .wr     (bus),
        .hold   (hold),
        .pc_inc (pc_inc),
        .r0     (r0),
        .r1     (r1),
        .r2     (r2),
        .r3     (r3),
        .r4     (r4),
        .r5     (r5),
        .r6     (r6),
        .r7     (r7)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic req(input logic v, input logic [2:0] c, input logic [1:0] o, input logic [15:0] d);
        bus.wr_valid = v;
        bus.wr_cmd   = c;
        bus.wr_op    = o;
        bus.wr_data  = d;
    endtask

    initial begin
        rst_n  = 1'b0;
        hold   = 1'b0;
        pc_inc = 1'b0;
        req(1'b0, 3'd0, 2'b00, 16'h0000);

        // reset values while rst_n low
        tick();
        tick();
        check("rst_r0", r0, 16'h0000);
        check("rst_r1", r1, 16'h0000);
        check("rst_r2", r2, 16'h0000);
        check("rst_r3", r3, 16'h0000);
        check("rst_r4", r4, 16'h0000);
        check("rst_r5", r5, 16'h0000);
        check("rst_r6", r6, 16'h0000);
        check("rst_r7", r7, R7_RST);
        rst_n = 1'b1;
        #1;
        check("rst_ready", {15'd0, bus.wr_ready}, 16'h0001);

        // LOAD r3 = 1234, one-cycle apply latency
        tick();
        req(1'b1, 3'd3, 2'b00, 16'h1234);
        tick();
        req(1'b0, 3'd0, 2'b00, 16'h0000);
        check("load_r3_lat", r3, 16'h0000);
        tick();
        check("load_r3", r3, 16'h1234);
        check("load_r2_untouched", r2, 16'h0000);
        check("load_r7_untouched", r7, R7_RST);

        // back-to-back LOAD r2=00AB then LOADH r2 with 00CD
        req(1'b1, 3'd2, 2'b00, 16'h00AB);
        tick();
        req(1'b1, 3'd2, 2'b01, 16'h00CD);
        tick();
        check("b2b_r2_first", r2, 16'h00AB);
        req(1'b0, 3'd0, 2'b00, 16'h0000);
        tick();
        check("loadh_r2", r2, 16'hCDAB);

        // INC wraps FFFF -> 0000
        req(1'b1, 3'd5, 2'b00, 16'hFFFF);
        tick();
        req(1'b1, 3'd5, 2'b10, 16'h1111);
        tick();
        check("r5_ffff", r5, 16'hFFFF);
        req(1'b0, 3'd0, 2'b00, 16'h0000);
        tick();
        check("inc_r5_wrap", r5, 16'h0000);

        // DEC wraps 0000 -> FFFF
        req(1'b1, 3'd1, 2'b11, 16'h2222);
        tick();
        req(1'b0, 3'd0, 2'b00, 16'h0000);
        tick();
        check("dec_r1_wrap", r1, 16'hFFFF);

        // hold back-pressure
        hold = 1'b1;
        req(1'b1, 3'd4, 2'b00, 16'h5555);
        #1;
        check("hold_ready_empty", {15'd0, bus.wr_ready}, 16'h0001);
        tick();
        req(1'b1, 3'd4, 2'b00, 16'hAAAA);
        #1;
        check("hold_ready0", {15'd0, bus.wr_ready}, 16'h0000);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("hold_r4_frozen", r4, 16'h0000);
            check("hold_ready_low", {15'd0, bus.wr_ready}, 16'h0000);
        end
        hold = 1'b0;
        #1;
        check("unhold_ready", {15'd0, bus.wr_ready}, 16'h0001);
        tick();
        check("unhold_apply", r4, 16'h5555);
        req(1'b0, 3'd0, 2'b00, 16'h0000);
        tick();
        check("unhold_second", r4, 16'hAAAA);

        // pc_inc with a competing LOAD r7
        pc_inc = 1'b1;
        tick();
        check("pc_inc1", r7, 16'hF001);
        req(1'b1, 3'd7, 2'b00, 16'h0100);
        tick();
        req(1'b0, 3'd0, 2'b00, 16'h0000);
        check("pc_inc2", r7, 16'hF002);
        tick();
        check("pc_load_wins", r7, 16'h0100);
        tick();
        check("pc_after_load", r7, 16'h0101);
        pc_inc = 1'b0;
        tick();
        check("pc_idle", r7, 16'h0101);

        // LOAD r0 = BEEF
        req(1'b1, 3'd0, 2'b00, 16'hBEEF);
        #1;
        check("r0_ready", {15'd0, bus.wr_ready}, 16'h0001);
        tick();
        req(1'b0, 3'd0, 2'b00, 16'h0000);
        tick();
`ifdef R0_ZERO_EN
        check("r0_zero", r0, 16'h0000);
`else
        check("r0_load", r0, 16'hBEEF);
`endif

        // async reset drops a buffered request
        req(1'b1, 3'd6, 2'b00, 16'h7777);
        tick();
        req(1'b0, 3'd0, 2'b00, 16'h0000);
        #1;
        rst_n = 1'b0;
        #1;
        check("arst_r3", r3, 16'h0000);
        check("arst_r7", r7, R7_RST);
        rst_n = 1'b1;
        tick();
        check("arst_discard_r6", r6, 16'h0000);
        check("arst_ready", {15'd0, bus.wr_ready}, 16'h0001);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
